// File: rtl/lbs_pkg.sv
// Shared definitions for the CAN status-poll scheduler: poll state encoding,
// default status register address and a constant width helper.
package lbs_pkg;

  // Poll engine states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_CAPT  = 2'd3
  } poll_state_e;

  // Status register read from every channel in a poll round
  localparam logic [7:0] STAT_ADDR_DEF = 8'h03;

  // Bits needed to hold values 0..n-1 (never less than one bit)
  function automatic int clog2(input int n);
    int w;
    w = 32'sd1;
    for (int i = 32'sd1; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < n) begin
        w = i + 32'sd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/lbs_poll_timer.sv
// Poll-round tick timer: counts 0..POLL_DIV-1 while enabled and flags the
// last count as a tick; a low enable parks the counter at zero.
module lbs_poll_timer
  import lbs_pkg::*;
#(
  parameter int POLL_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            TW   = clog2(POLL_DIV);
  localparam logic [TW-1:0] LAST = TW'(POLL_DIV - 1);

  logic [TW-1:0] cnt;

  // Free-running divider, held at zero while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/lbs_can_poll.sv
// Status-poll scheduler sharing the CAN register bus between the host and an
// autonomous poll engine. Host accesses pass straight through and always win;
// the poll engine only drives the bus after GUARD host-idle cycles.
// Optional feature macro: LBS_POLL_STICKY_EN (sticky status bytes + stat_clr).
module lbs_can_poll
  import lbs_pkg::*;
#(
  parameter int         CAN_NUMS  = 4,
  parameter int         POLL_DIV  = 1000,
  parameter int         GUARD     = 2,
  parameter logic [7:0] STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  poll_en,
  input  logic [7:0]            h_addr,
  input  logic [7:0]            h_din,
  input  logic                  h_we,
  input  logic                  h_re,
  input  logic [CAN_NUMS-1:0]   h_cs_n,
  output logic [7:0]            can_lbs_addr,
  output logic [7:0]            can_lbs_din,
  output logic                  can_lbs_we,
  output logic                  can_lbs_re,
  output logic [CAN_NUMS-1:0]   can_lbs_cs_n,
  input  logic [8*CAN_NUMS-1:0] can_lbs_dout,
  output logic [8*CAN_NUMS-1:0] stat,
  output logic [CAN_NUMS-1:0]   stat_vld,
  output logic                  poll_ovr
`ifdef LBS_POLL_STICKY_EN
  ,
  input  logic [CAN_NUMS-1:0]   stat_clr
`endif
);

  localparam int             CHW     = clog2(CAN_NUMS);
  localparam int             GW      = clog2(GUARD + 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CAN_NUMS - 1);
  localparam logic [GW-1:0]  GUARD_M = GW'(GUARD - 1);

  poll_state_e state, state_nxt;
  logic [GW-1:0]  guard, guard_nxt;
  logic [CHW-1:0] ch, ch_nxt;
  logic           ovr_nxt;
  logic           capt;
  logic           tick;
  logic           host_act;
  logic [7:0]     cap_byte;

  logic [CAN_NUMS-1:0] poll_cs_n;
  logic                poll_re;

  lbs_poll_timer #(
    .POLL_DIV (POLL_DIV)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (poll_en),
    .tick (tick)
  );

  assign host_act = (~&h_cs_n) | h_we | h_re;
  assign cap_byte = can_lbs_dout[8*ch +: 8];

  // Poll state, guard count, channel index and overrun pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      guard    <= '0;
      ch       <= '0;
      poll_ovr <= 1'b0;
    end else begin
      state    <= state_nxt;
      guard    <= guard_nxt;
      ch       <= ch_nxt;
      poll_ovr <= ovr_nxt;
    end
  end

  // Next-state logic: round start on tick, guard wait, issue with host
  // pre-emption, capture and advance to the next channel
  always_comb begin
    state_nxt = state;
    guard_nxt = guard;
    ch_nxt    = ch;
    ovr_nxt   = 1'b0;
    capt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nxt = ST_WAIT;
          ch_nxt    = '0;
          guard_nxt = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        ovr_nxt = tick;
        if (host_act) begin
          guard_nxt = '0;
        end else if (guard == GUARD_M) begin
          guard_nxt = '0;
          state_nxt = ST_ISSUE;
        end else begin
          guard_nxt = guard + GW'(1);
        end
      end
      ST_ISSUE: begin
        ovr_nxt = tick;
        if (host_act) begin
          // Host took the bus: the poll read is void, retry this channel
          guard_nxt = '0;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_CAPT;
        end
      end
      ST_CAPT: begin
        ovr_nxt = tick;
        capt    = 1'b1;
        if (ch == LAST_CH) begin
          state_nxt = ST_IDLE;
        end else begin
          ch_nxt    = ch + CHW'(1);
          guard_nxt = '0;
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        guard_nxt = '0;
        ch_nxt    = '0;
      end
    endcase
  end

  // Poll-side bus drive, registered so it is only active during ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cs_n <= '1;
      poll_re   <= 1'b0;
    end else if (state_nxt == ST_ISSUE) begin
      for (int i = 0; i < CAN_NUMS; i++) begin
        poll_cs_n[i] <= (ch_nxt != CHW'(i));
      end
      poll_re <= 1'b1;
    end else begin
      poll_cs_n <= '1;
      poll_re   <= 1'b0;
    end
  end

  // Bus mux: host passes through combinationally, otherwise the poll drive
  always_comb begin
    if (host_act) begin
      can_lbs_addr = h_addr;
      can_lbs_din  = h_din;
      can_lbs_we   = h_we;
      can_lbs_re   = h_re;
      can_lbs_cs_n = h_cs_n;
    end else begin
      can_lbs_addr = poll_re ? STAT_ADDR : 8'h00;
      can_lbs_din  = 8'h00;
      can_lbs_we   = 1'b0;
      can_lbs_re   = poll_re;
      can_lbs_cs_n = poll_cs_n;
    end
  end

  // Status bytes and their update strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      stat     <= '0;
      stat_vld <= '0;
    end else begin
      for (int i = 0; i < CAN_NUMS; i++) begin
        stat_vld[i] <= capt && (ch == CHW'(i));
`ifdef LBS_POLL_STICKY_EN
        if (capt && (ch == CHW'(i))) begin
          // A clear in the capture cycle loads the new byte alone
          stat[8*i +: 8] <= (stat_clr[i] ? 8'h00 : stat[8*i +: 8]) | cap_byte;
        end else if (stat_clr[i]) begin
          stat[8*i +: 8] <= 8'h00;
        end else begin
          stat[8*i +: 8] <= stat[8*i +: 8];
        end
`else
        if (capt && (ch == CHW'(i))) begin
          stat[8*i +: 8] <= cap_byte;
        end else begin
          stat[8*i +: 8] <= stat[8*i +: 8];
        end
`endif
      end
    end
  end

endmodule
